fib_job_scheduler: RTL
======================

// Module: fib_job_scheduler
// PURPOSE
//  Shares one Fibonacci sequence engine (start/done handshake) among NREQ requesters.
//  Round-robin grant; latches the winner's argument; issues one job; returns the result tagged with the requester id.
//  Sits between the HPS-facing Avalon-MM wrappers (one per requester) and the single engine instance.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  DW          32    argument/result width
//  IDW         2     requester id width, = clog2(NREQ)
//  TIMEOUT_CYC 4096  engine watchdog limit in cycles (used only with FIB_SCHED_TIMEOUT_EN)
// PORTS
//  clk         in   1        clock
//  reset_n     in   1        async active-low reset
//  req_valid   in   NREQ     per-requester job request
//  req_arg     in   NREQ*DW  per-requester argument; slice i = [i*DW +: DW]
//  req_ready   out  NREQ     one-hot accept pulse; job taken when valid&ready
//  rsp_valid   out  1        result available
//  rsp_ready   in   1        consumer accepts result
//  rsp_id      out  IDW      requester that owns the result
//  rsp_data    out  DW       engine result
//  rsp_err     out  1        job aborted by watchdog (always 0 without the macro)
//  eng_start   out  1        single-cycle engine start pulse
//  eng_arg     out  DW       engine argument, stable from start until done
//  eng_abort   out  1        single-cycle engine abort pulse (tied 0 without the macro)
//  eng_done    in   1        engine finished; eng_result is valid in the same cycle
//  eng_result  in   DW       engine result
//  busy        out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0,
//   eng_start=0, eng_abort=0, eng_arg=0, busy=0. Reset mid-job drops the job silently; engine shares reset_n.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
//  IDLE: if any req_valid: grant = first asserted index at or after rr_ptr (wrapping);
//   latch req_arg[grant] into eng_arg and grant into id; req_ready[grant]=1 for that one cycle; -> ISSUE.
//  ISSUE: eng_start=1 for exactly one cycle; -> WAIT.
//  WAIT: on eng_done: rsp_data<=eng_result, rsp_err<=0; -> RESP. eng_done outside WAIT is ignored.
//  RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_err held stable until rsp_ready.
//   On rsp_valid&rsp_ready: rsp_valid<=0; rr_ptr<=(id+1) mod NREQ; -> IDLE.
//  Latency: request accept to eng_start = 1 cycle; eng_done to rsp_valid = 1 cycle;
//   minimum 2 idle cycles between jobs, so back-to-back throughput is one job per (engine time + 4) cycles.
//  Requesters drop req_valid only after req_ready. A requester deasserting early is not granted; no partial state is kept.
//  Requests arriving in non-IDLE states wait; no queueing beyond the one in-flight job.
//  rr_ptr wraps NREQ-1 -> 0. With a single active requester, it is re-granted every job.
//  eng_arg=0 is passed through unchanged; result semantics belong to the engine.
// CONFIGURATION
//  FIB_SCHED_TIMEOUT_EN defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle.
//   At TIMEOUT_CYC without eng_done: eng_abort=1 for one cycle, rsp_data<=0, rsp_err<=1; -> RESP.
//   If eng_done and timeout occur in the same cycle, eng_done wins (rsp_err=0, no abort).
//  Undefined: no counter; WAIT lasts until eng_done indefinitely; eng_abort and rsp_err are constant 0.
// STRUCTURE
//  fib_sched_pkg: state enum {IDLE, ISSUE, WAIT, RESP}; default DW, NREQ and TIMEOUT_CYC constants.
//  Sub-module rr_arbiter (req vector, ptr) -> (one-hot grant, encoded index, any); purely combinational.
//   Its output is registered in this block.
// TESTING
//  1. Single job: req_valid[1]=1, arg=10 -> req_ready[1] pulse; next cycle eng_start=1, eng_arg=10;
//     model eng_done+result=55 -> next cycle rsp_valid, rsp_id=1, rsp_data=55.
//  2. Round robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0; each rsp_id matches.
//  3. Backpressure: rsp_ready=0 for 20 cycles -> rsp fields stable; no new req_ready; accepted after release.
//  4. Wrap: rr_ptr=3, only req 0 and 2 valid -> grant 0, then 2.
//  5. Reset in WAIT: reset_n low 3 cycles -> all outputs reset values; stale eng_done after reset gives no rsp.
//  6. Timeout (macro on, TIMEOUT_CYC=16): engine never done -> eng_abort pulse 16 cycles after start,
//     rsp_err=1, rsp_data=0. Same-cycle done+timeout -> rsp_err=0.

Source files
------------

// File: rtl/fib_sched_pkg.sv
// Shared types and default sizing for the Fibonacci job scheduler.
// No logic: the scheduler FSM state encoding and parameter defaults only.
// Backpressure: n/a (declarations only).
package fib_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_DW          = 32;
  localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/fib_job_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping past NREQ-1.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none; requests not picked simply stay asserted at the source.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int pos;

  // Scan NREQ slots starting at ptr and keep only the first hit.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        idx      = IDW'(pos);
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_job_scheduler.sv
// Shares one Fibonacci engine among NREQ requesters with round-robin grant; optional watchdog via FIB_SCHED_TIMEOUT_EN.
// Latency: accept -> eng_start 1 cycle; eng_done -> rsp_valid 1 cycle; one job in flight at a time.
// Backpressure: rsp held stable until rsp_ready; no new request is accepted until the response is taken.
module fib_job_scheduler
  import fib_sched_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int DW          = DEF_DW,
  parameter int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_arg,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               eng_start,
  output logic [DW-1:0]      eng_arg,
  output logic               eng_abort,
  input  logic               eng_done,
  input  logic [DW-1:0]      eng_result,
  output logic               busy
);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  next_ptr;
  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // rsp_id doubles as the in-flight job owner; the pointer moves just past it.
  assign next_ptr = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);

`ifdef FIB_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] wait_cnt;
`endif

  // Job FSM: grant, issue, wait for engine, hold response; every output is a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      eng_arg   <= '0;
      busy      <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      // Pulse outputs default low so each lasts exactly one cycle.
      req_ready <= '0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            req_ready <= arb_gnt;
            eng_arg   <= req_arg[int'(arb_idx)*DW +: DW];
            rsp_id    <= arb_idx;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start <= 1'b1;
          state     <= WAIT;
`ifdef FIB_SCHED_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        WAIT: begin
          // A completion in the same cycle as the watchdog limit still counts as success.
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef FIB_SCHED_TIMEOUT_EN
          // TIMEOUT_CYC wait cycles without done: abort lands TIMEOUT_CYC cycles after eng_start.
          else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            eng_abort <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt  <= wait_cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
